alu_issue_sched: RTL

Issue scheduler and write-back sequencer for the 3-stage ALU/multiplier datapath. Buffers incoming instructions with their operands in a small FIFO and issues at most one per cycle to the ALU. It holds single-cycle ops while any multiply is in flight, because the ALU result mux belongs to the multiplier during that time. It captures each result into a registered write-back port, in issue order.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/alu_issue_sched.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, instruction class decode and default multiplier latency
package alu_pkg;

    localparam logic [3:0] OP_ADD         = 4'h0;
    localparam logic [3:0] OP_SUB         = 4'h1;
    localparam logic [3:0] OP_AND         = 4'h2;
    localparam logic [3:0] OP_OR          = 4'h3;
    localparam logic [3:0] OP_XOR         = 4'h4;
    localparam logic [3:0] OP_MUL         = 4'h5;
    localparam logic [3:0] OP_NOT         = 4'h6;
    localparam logic [3:0] OP_SLL         = 4'h7;
    localparam logic [3:0] OP_SRA         = 4'h8;
    localparam logic [3:0] OP_MOV         = 4'h9;
    localparam logic [3:0] OP_SRL         = 4'hA;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'hB;

    localparam int MUL_LAT_DEF = 3;

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op >= OP_ILLEGAL_MIN;
    endfunction

    function automatic logic is_single(input logic [3:0] op);
        return !is_mul(op) && !is_illegal(op);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two request FIFO with flush; head is presented combinationally
module sync_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);

    // Pointers and occupancy; flush wins over a same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage array needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: buffers ALU requests, issues in order around multiplier hazards, sequences write-back
module alu_issue_sched
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_rs1,
    input  logic [15:0] in_rs2,
    input  logic        flush,
    output logic [15:0] alu_instr,
    output logic [15:0] alu_rs1,
    output logic [15:0] alu_rs2,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_ex_instr,
    output logic        wb_valid,
    output logic [15:0] wb_instr,
    output logic [15:0] wb_data,
    output logic        err,
    output logic        busy,
    output logic [15:0] stall_cnt
);
    logic [47:0]              head;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic [MUL_LAT-2:0]       p;
    logic [3:0]               op;
    logic                     can;
    logic                     issue_mul;
    logic                     issue_single;
    logic                     drop;
    logic                     stall;
    logic                     pop;
    logic                     push;

    sync_fifo #(.W(48), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({in_instr, in_rs1, in_rs2}),
        .rdata (head),
        .count (count),
        .full  (full)
    );

    assign op       = head[47:44];
    assign in_ready = !full;
    assign busy     = (count != '0) || (p != '0);

    // Issue decision for the FIFO head; a single-cycle op waits while the multiplier owns alu_out
    always_comb begin
        can          = (count != '0) && !flush;
        issue_mul    = can && is_mul(op);
        issue_single = can && is_single(op) && (p == '0);
        drop         = can && is_illegal(op);
        stall        = can && is_single(op) && (p != '0);
        pop          = issue_mul || issue_single || drop;
        push         = in_valid && !full;
        alu_instr    = (issue_mul || issue_single) ? head[47:32] : 16'h0000;
        alu_rs1      = (issue_mul || issue_single) ? head[31:16] : 16'h0000;
        alu_rs2      = (issue_mul || issue_single) ? head[15:0]  : 16'h0000;
    end

    // Multiplier tracker, write-back capture, illegal-op flag and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            wb_valid  <= 1'b0;
            wb_instr  <= 16'h0000;
            wb_data   <= 16'h0000;
            err       <= 1'b0;
            stall_cnt <= 16'h0000;
        end else begin
            p        <= (p << 1) | (MUL_LAT-1)'(issue_mul);
            wb_valid <= issue_single || p[MUL_LAT-2];
            if (issue_single || p[MUL_LAT-2]) begin
                wb_instr <= issue_single ? head[47:32] : alu_ex_instr;
                wb_data  <= alu_out;
            end
            err <= drop;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
